// File: rtl/producer_scheduler_if.sv
// Buffer-side signals between producer_scheduler (master) and the CDC wrapper / data mux (slave).
interface producer_scheduler_if;
  logic       buffer_full;
  logic       buffer_empty;
  logic       data_2_valid;
  logic       f_en;
  logic       t_en;
  logic [1:0] modulo;

  modport master (
    input  buffer_full, buffer_empty, data_2_valid,
    output f_en, t_en, modulo
  );

  modport slave (
    output buffer_full, buffer_empty, data_2_valid,
    input  f_en, t_en, modulo
  );
endinterface

// File: rtl/producer_scheduler.sv
// Round-robin arbiter sharing one CDC buffer between the fibonacci and timer producers.
// Optional drain watchdog: define PROD_SCHED_WATCHDOG_EN.
module producer_scheduler #(
  parameter int QUANTUM   = 16,
  parameter int DRAIN_TMO = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_f,
  input  logic                        start_t,
  input  logic                        stop_f_t,
  producer_scheduler_if.master        bus,
  output logic                        owner,
  output logic [1:0]                  armed,
  output logic [3:0]                  state_led,
  output logic                        tmo_err
);

  localparam int CNT_W = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(QUANTUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             arm_f;
  logic             arm_t;
  logic [CNT_W-1:0] slice_cnt;
  logic             start_f_q;
  logic             start_t_q;
  logic             start_f_rise;
  logic             start_t_rise;
  logic             both_armed;
  logic             drain_done;
  logic             drain_tmo;
  logic             grant_f;
  logic             grant_t;

  always_ff @(posedge clk) begin
    if (!rst) begin
      start_f_q <= 1'b0;
      start_t_q <= 1'b0;
    end else begin
      start_f_q <= start_f;
      start_t_q <= start_t;
    end
  end

  assign start_f_rise = start_f & ~start_f_q;
  assign start_t_rise = start_t & ~start_t_q;
  assign both_armed   = arm_f & arm_t;
  assign drain_done   = bus.buffer_empty & ~bus.data_2_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!stop_f_t && (start_f_rise || start_t_rise)) state_next = S_GRANT;
      end
      S_GRANT: begin
        if (stop_f_t)             state_next = S_DRAIN;
        else if (bus.buffer_full) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (stop_f_t)              state_next = S_DRAIN;
        else if (!bus.buffer_full) state_next = S_GRANT;
      end
      S_DRAIN: begin
        if (drain_done || drain_tmo) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Arms, slice owner and slice counter; the counter only advances while both sources share the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arm_f     <= 1'b0;
      arm_t     <= 1'b0;
      owner     <= 1'b0;
      slice_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!stop_f_t && (start_f_rise || start_t_rise)) begin
            arm_f <= start_f_rise;
            arm_t <= start_t_rise;
            owner <= ~start_f_rise;
          end
        end
        S_GRANT, S_WAIT: begin
          if (stop_f_t) begin
            arm_f <= 1'b0;
            arm_t <= 1'b0;
          end else begin
            if (state == S_GRANT && !bus.buffer_full && both_armed) begin
              if (slice_cnt == SLICE_LAST) begin
                slice_cnt <= '0;
                owner     <= ~owner;
              end else begin
                slice_cnt <= slice_cnt + 1'b1;
              end
            end
            if (start_f_rise) arm_f <= 1'b1;
            if (start_t_rise) arm_t <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (state_next == S_IDLE) begin
            owner     <= 1'b0;
            slice_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PROD_SCHED_WATCHDOG_EN
  localparam int DRAIN_W = $clog2(DRAIN_TMO + 1);

  logic [DRAIN_W-1:0] drain_cnt;

  assign drain_tmo = (state == S_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_TMO - 1));

  // A clean drain finishing on the last allowed cycle is not a timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_cnt <= '0;
      tmo_err   <= 1'b0;
    end else begin
      if (state != S_DRAIN) drain_cnt <= '0;
      else                  drain_cnt <= drain_cnt + 1'b1;
      if (drain_tmo && !drain_done) tmo_err <= 1'b1;
    end
  end
`else
  assign drain_tmo = 1'b0;
  assign tmo_err   = 1'b0;
`endif

  always_comb begin
    grant_f   = 1'b0;
    grant_t   = 1'b0;
    state_led = 4'b0001;
    case (state)
      S_IDLE:  state_led = 4'b0001;
      S_GRANT: begin
        state_led = 4'b0010;
        grant_f   = ~owner;
        grant_t   = owner;
      end
      S_WAIT:  state_led = 4'b0100;
      S_DRAIN: state_led = 4'b1000;
      default: state_led = 4'b0001;
    endcase
  end

  assign bus.f_en   = grant_f;
  assign bus.t_en   = grant_t;
  assign bus.modulo = {grant_f, grant_t};
  assign armed      = {arm_f, arm_t};

endmodule

// File: tb/tb_producer_scheduler.sv
// Self-checking bench for producer_scheduler: vector table, directed corner sequences and
// randomized traffic against a slice-budget reference model.
module tb_producer_scheduler;

  localparam int QUANTUM   = 16;
  localparam int DRAIN_TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_f = 1'b0;
  logic       start_t = 1'b0;
  logic       stop_f_t = 1'b0;
  logic       owner;
  logic [1:0] armed;
  logic [3:0] state_led;
  logic       tmo_err;

  producer_scheduler_if bus();

  producer_scheduler #(
    .QUANTUM   (QUANTUM),
    .DRAIN_TMO (DRAIN_TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_f   (start_f),
    .start_t   (start_t),
    .stop_f_t  (stop_f_t),
    .bus       (bus),
    .owner     (owner),
    .armed     (armed),
    .state_led (state_led),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit rst;
    bit sf;
    bit st;
    bit stop;
    bit full;
    bit empty;
    bit dv;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [3:0] led;
    logic [1:0] arm;
    logic       own;
    logic [1:0] en;
    string      tag;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  int cycle_no   = 0;

  // Reference model: mode name, per-source arm flags, owner and remaining cycles in the slice.
  string m_mode = "idle";
  bit    m_arm_f, m_arm_t, m_owner, m_prev_f, m_prev_t, m_tmo;
  int    m_left = QUANTUM;
  int    m_drain = 0;

  vec_t  tbl[$];

  function automatic stim_t stim(bit r, bit sf, bit st, bit sp, bit fu, bit em, bit dv);
    stim_t s;
    s.rst = r; s.sf = sf; s.st = st; s.stop = sp; s.full = fu; s.empty = em; s.dv = dv;
    return s;
  endfunction

  task automatic modelReset();
    m_mode = "idle"; m_arm_f = 0; m_arm_t = 0; m_owner = 0;
    m_prev_f = 0; m_prev_t = 0; m_tmo = 0; m_left = QUANTUM; m_drain = 0;
  endtask

  task automatic modelStep(input stim_t s);
    bit sf, st;
    sf = s.sf && !m_prev_f;
    st = s.st && !m_prev_t;
    m_prev_f = s.sf;
    m_prev_t = s.st;
    if (m_mode == "idle") begin
      if (!s.stop && (sf || st)) begin
        m_arm_f = sf; m_arm_t = st; m_owner = !sf; m_left = QUANTUM; m_mode = "run";
      end
    end else if (m_mode == "run" || m_mode == "paused") begin
      if (s.stop) begin
        m_arm_f = 0; m_arm_t = 0; m_mode = "drain"; m_drain = 0;
      end else begin
        if (m_mode == "run") begin
          if (s.full) m_mode = "paused";
          else if (m_arm_f && m_arm_t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_owner = !m_owner;
              m_left  = QUANTUM;
            end
          end
        end else if (!s.full) begin
          m_mode = "run";
        end
        if (sf) m_arm_f = 1;
        if (st) m_arm_t = 1;
      end
    end else begin
      m_drain = m_drain + 1;
      if (s.empty && !s.dv) begin
        m_mode = "idle"; m_owner = 0; m_left = QUANTUM;
      end
`ifdef PROD_SCHED_WATCHDOG_EN
      else if (m_drain == DRAIN_TMO) begin
        m_mode = "idle"; m_owner = 0; m_left = QUANTUM; m_tmo = 1;
      end
`endif
    end
  endtask

  function automatic logic [11:0] modelOut();
    logic       fe, te;
    logic [3:0] led;
    fe = (m_mode == "run") && !m_owner;
    te = (m_mode == "run") && m_owner;
    if (m_mode == "idle")        led = 4'b0001;
    else if (m_mode == "run")    led = 4'b0010;
    else if (m_mode == "paused") led = 4'b0100;
    else                         led = 4'b1000;
    return {m_tmo, led, m_arm_f, m_arm_t, m_owner, fe, te, fe, te};
  endfunction

  function automatic logic [11:0] dutOut();
    return {tmo_err, state_led, armed, owner, bus.modulo, bus.f_en, bus.t_en};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", name, actual, expected, cycle_no, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input string tag);
    rst              = s.rst;
    start_f          = s.sf;
    start_t          = s.st;
    stop_f_t         = s.stop;
    bus.buffer_full  = s.full;
    bus.buffer_empty = s.empty;
    bus.data_2_valid = s.dv;
    @(posedge clk);
    if (!s.rst) modelReset();
    else        modelStep(s);
    #1;
    cycle_no++;
    checkOutput({tag, "_model"}, 16'(dutOut()), 16'(modelOut()));
  endtask

  task automatic addVec(input stim_t s, input logic [3:0] led, input logic [1:0] arm,
                        input logic own, input logic [1:0] en, input string tag);
    vec_t v;
    v.s = s; v.led = led; v.arm = arm; v.own = own; v.en = en; v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic resetDut();
    applyStimulus(stim(0, 0, 0, 0, 0, 0, 0), "rst");
    applyStimulus(stim(0, 0, 0, 0, 0, 0, 0), "rst");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t nop;
    int    cnt, bad, runlen;
    bit    full_state;
    nop = stim(1, 0, 0, 0, 0, 0, 0);

    addVec(stim(0,0,0,0,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "reset");
    addVec(stim(1,0,0,0,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "idle");
    addVec(stim(1,0,0,1,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "stop_idle");
    addVec(stim(1,0,1,0,0,0,0), 4'b0010, 2'b01, 1'b1, 2'b01, "start_t");
    addVec(stim(1,0,0,0,0,0,0), 4'b0010, 2'b01, 1'b1, 2'b01, "grant_t");
    addVec(stim(1,0,0,0,1,0,0), 4'b0100, 2'b01, 1'b1, 2'b00, "full_wait");
    addVec(stim(1,1,0,0,1,0,0), 4'b0100, 2'b11, 1'b1, 2'b00, "wait_arm_f");
    addVec(stim(1,0,0,0,0,0,0), 4'b0010, 2'b11, 1'b1, 2'b01, "resume_t");
    addVec(stim(1,1,0,1,0,0,0), 4'b1000, 2'b00, 1'b1, 2'b00, "stop_grant");
    addVec(stim(1,0,1,0,0,0,0), 4'b1000, 2'b00, 1'b1, 2'b00, "drain_start_ign");
    addVec(stim(1,0,0,0,0,1,1), 4'b1000, 2'b00, 1'b1, 2'b00, "drain_dv");
    addVec(stim(1,0,0,0,0,1,0), 4'b0001, 2'b00, 1'b0, 2'b00, "drain_exit");
    addVec(stim(1,1,1,0,0,0,0), 4'b0010, 2'b11, 1'b0, 2'b10, "start_both");
    addVec(stim(1,0,0,1,0,0,0), 4'b1000, 2'b00, 1'b0, 2'b00, "stop2");
    addVec(stim(1,0,0,0,0,1,0), 4'b0001, 2'b00, 1'b0, 2'b00, "drain_exit2");
    addVec(stim(1,1,0,1,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "stop_start_idle");
    addVec(stim(1,1,0,0,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "start_held");
    addVec(stim(1,0,0,0,0,0,0), 4'b0001, 2'b00, 1'b0, 2'b00, "start_low");
    addVec(stim(1,1,0,0,0,0,0), 4'b0010, 2'b10, 1'b0, 2'b10, "start_f");

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s, tbl[i].tag);
      checkOutput(tbl[i].tag, 16'({state_led, armed, owner, bus.f_en, bus.t_en}),
                  16'({tbl[i].led, tbl[i].arm, tbl[i].own, tbl[i].en}));
    end

    // Stop together with start_t from an F grant; start_t during drain must not re-arm.
    applyStimulus(nop, "t5_pre");
    applyStimulus(stim(1,0,1,1,0,0,0), "t5_stop");
    checkOutput("t5_stop_start", 16'({state_led, armed}), 16'({4'b1000, 2'b00}));
    applyStimulus(nop, "t5_low");
    applyStimulus(stim(1,0,1,0,0,0,0), "t5_ign");
    checkOutput("t5_drain_ign", 16'({state_led, armed}), 16'({4'b1000, 2'b00}));
    applyStimulus(stim(1,0,0,0,0,1,0), "t5_exit");

    // Single producer keeps the buffer with no owner changes.
    resetDut();
    applyStimulus(stim(1,1,0,0,0,0,0), "t1_start");
    checkOutput("t1_latency", 16'({bus.f_en, bus.modulo}), 16'({1'b1, 2'b10}));
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(nop, "t1_run");
      if (bus.f_en && bus.modulo == 2'b10 && owner == 1'b0 && !bus.t_en) cnt++;
    end
    checkOutput("t1_f_cycles", 16'(cnt), 16'd100);

    // Timer joins 5 cycles later: QUANTUM-cycle slices alternate from the join onward.
    resetDut();
    applyStimulus(stim(1,1,0,0,0,0,0), "t2_start_f");
    for (int i = 0; i < 4; i++) applyStimulus(nop, "t2_solo");
    applyStimulus(stim(1,0,1,0,0,0,0), "t2_start_t");
    bad = 0;
    for (int j = 0; j < 4 * QUANTUM; j++) begin
      if (j > 0) applyStimulus(nop, "t2_rot");
      if (((j / QUANTUM) % 2) == 0) begin
        if (!(bus.f_en && !bus.t_en)) bad++;
      end else begin
        if (!(bus.t_en && !bus.f_en)) bad++;
      end
    end
    checkOutput("t2_rotation", 16'(bad), 16'd0);

    // Buffer full at slice cycle 7 for 10 cycles: owner resumes with 9 cycles left.
    resetDut();
    applyStimulus(stim(1,1,1,0,0,0,0), "t3_start");
    for (int i = 0; i < 7; i++) applyStimulus(nop, "t3_slice");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(stim(1,0,0,0,1,0,0), "t3_full");
      if (state_led == 4'b0100 && !bus.f_en && !bus.t_en) cnt++;
    end
    checkOutput("t3_wait_cycles", 16'(cnt), 16'd10);
    runlen = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(nop, "t3_release");
      if (bus.f_en) runlen++;
      else break;
    end
    checkOutput("t3_resume_len", 16'(runlen), 16'd9);
    checkOutput("t3_next_owner", 16'({bus.t_en, owner}), 16'({1'b1, 1'b1}));

`ifndef PROD_SCHED_WATCHDOG_EN
    // Long drain: stays in DRAIN until the buffer reports empty with no valid data.
    resetDut();
    applyStimulus(stim(1,1,0,0,0,0,0), "t4_start");
    applyStimulus(stim(1,0,0,1,0,0,0), "t4_stop");
    cnt = (state_led == 4'b1000) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(nop, "t4_drain");
      if (state_led == 4'b1000 && !bus.f_en && !bus.t_en) cnt++;
    end
    checkOutput("t4_drain_cycles", 16'(cnt), 16'd21);
    applyStimulus(stim(1,0,0,0,0,1,0), "t4_exit");
    checkOutput("t4_idle", 16'({state_led, armed, tmo_err}), 16'({4'b0001, 2'b00, 1'b0}));
`else
    // Stuck drain: watchdog forces IDLE after DRAIN_TMO cycles and tmo_err sticks until reset.
    resetDut();
    applyStimulus(stim(1,1,0,0,0,0,0), "t6_start");
    applyStimulus(stim(1,0,0,1,0,0,0), "t6_stop");
    cnt = (state_led == 4'b1000) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(nop, "t6_drain");
      if (state_led == 4'b1000) cnt++;
    end
    checkOutput("t6_drain_cycles", 16'(cnt), 16'(DRAIN_TMO));
    checkOutput("t6_tmo_set", 16'({state_led, tmo_err}), 16'({4'b0001, 1'b1}));
    applyStimulus(stim(1,1,0,0,0,0,0), "t6_restart");
    applyStimulus(nop, "t6_run");
    checkOutput("t6_tmo_sticky", 16'({tmo_err, bus.f_en}), 16'({1'b1, 1'b1}));
    applyStimulus(stim(0,0,0,0,0,0,0), "t6_rst");
    checkOutput("t6_tmo_clear", 16'(tmo_err), 16'd0);
`endif

    // Randomized traffic against the reference model.
    resetDut();
    full_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) full_state = !full_state;
      applyStimulus(stim((i % 997) != 500,
                         $urandom_range(0, 9) == 0,
                         $urandom_range(0, 9) == 0,
                         $urandom_range(0, 39) == 0,
                         full_state,
                         $urandom_range(0, 3) == 0,
                         $urandom_range(0, 1) == 0), "rand");
      if (bus.f_en && bus.t_en) begin
        checkOutput("rand_both_en", 16'({bus.f_en, bus.t_en}), 16'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
